// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, frame size and parity helper for the PS/2 transmitter
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} ps2_state_e;
  localparam int FRAME_BITS = 11;
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: valid/ready byte port from a scancode source into the transmitter
interface ps2_kbd_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  modport master (output din, output din_valid, input din_ready);
  modport slave (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: synchronous first-word-fall-through byte FIFO with full/empty flags
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_comb begin
    wp_d = wp_q + (AW+1)'(wr && !full);
    rp_d = rp_q + (AW+1)'(rd && !empty);
  end
  // pointer registers
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge clk14) begin
    if (wr && !full) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 frame serialiser; PS2_TX_FIFO_EN selects a byte FIFO over a holding register
module ps2_kbd_tx import ps2_pkg::*; #(
  parameter int CLK_HZ     = 14318180,
  parameter int PS2_HZ     = 12000,
  parameter int GAP_HALVES = 4
`ifdef PS2_TX_FIFO_EN
  , parameter int FIFO_DEPTH = 8
`endif
) (
  input  logic         clk14,
  input  logic         rst_n,
  ps2_kbd_tx_if.slave  bus,
  input  logic         inhibit,
  output logic         ps2_clk,
  output logic         ps2_data,
  output logic         busy
);
  localparam int HALF_DIV = CLK_HZ / (2 * PS2_HZ);
  localparam int HW = $clog2(HALF_DIV);
  localparam int GW = $clog2(GAP_HALVES + 1);
  ps2_state_e state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [9:0] shift_q, shift_d;
  logic ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;
  logic tick, pop, push, buf_full, buf_empty;
  logic [7:0] buf_data;
  assign push          = bus.din_valid && !buf_full;
  assign bus.din_ready = !buf_full;
  assign busy          = (state_q != IDLE) || !buf_empty;
  assign ps2_clk       = ps2_clk_q;
  assign ps2_data      = ps2_data_q;
`ifdef PS2_TX_FIFO_EN
  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk14(clk14), .rst_n(rst_n), .wr(push), .rd(pop), .din(bus.din),
    .dout(buf_data), .full(buf_full), .empty(buf_empty)
  );
`else
  logic hold_valid_q, hold_valid_d;
  logic [7:0] hold_q, hold_d;
  assign buf_full  = hold_valid_q;
  assign buf_empty = !hold_valid_q;
  assign buf_data  = hold_q;
  // one byte waits here while the previous frame shifts out; push and pop never coincide
  always_comb begin
    hold_valid_d = push ? 1'b1 : (pop ? 1'b0 : hold_valid_q);
    hold_d       = push ? bus.din : hold_q;
  end
  // holding register
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end
`endif
  // half-bit timer plus frame sequencing: start, 8 data LSB first, odd parity, stop, then idle gap
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    pop        = 1'b0;
    tick       = (state_q != IDLE) && (half_q == HW'(HALF_DIV - 1));
    half_d     = (state_q == IDLE || tick) ? '0 : half_q + 1'b1;
    case (state_q)
      IDLE: if (!buf_empty && !inhibit) begin
        pop        = 1'b1;
        shift_d    = {1'b1, odd_par(buf_data), buf_data};
        ps2_data_d = 1'b0;
        bit_d      = '0;
        state_d    = HIGH;
      end
      HIGH: if (tick) begin
        ps2_clk_d = 1'b0;
        state_d   = LOW;
      end
      LOW: if (tick) begin
        ps2_clk_d = 1'b1;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          ps2_data_d = 1'b1;
          gap_d      = '0;
          state_d    = GAP;
        end else begin
          bit_d      = bit_q + 1'b1;
          ps2_data_d = shift_q[0];
          shift_d    = {1'b0, shift_q[9:1]};
          state_d    = HIGH;
        end
      end
      GAP: if (tick) begin
        gap_d   = gap_q + 1'b1;
        state_d = (gap_q == GW'(GAP_HALVES - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and line registers; reset aborts any frame and releases the lines high
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      half_q     <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: scoreboard bench; a PS/2 receiver monitor checks every frame against queued expectations
`timescale 1ns/1ps
module tb_ps2_kbd_tx;
  // clock rate scaled so one half-bit is 20 clocks, keeping the run short
  localparam int HALF  = 20;
  localparam int GAPH  = 4;
  localparam int FRAME = 22 * HALF;
`ifdef PS2_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  logic clk14 = 1'b0, rst_n = 1'b0, inhibit = 1'b0;
  logic ps2_clk, ps2_data, busy;
  ps2_kbd_tx_if bus();
  ps2_kbd_tx #(.CLK_HZ(HALF * 2 * 12000), .PS2_HZ(12000), .GAP_HALVES(GAPH)) dut (
    .clk14(clk14), .rst_n(rst_n), .bus(bus), .inhibit(inhibit),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
  );
  always #5 clk14 = ~clk14;

  int tests = 0, fails = 0, cyc = 0, edges = 0, nbits = 0, t_start = 0;
  logic prev_clk = 1'b1, in_frame = 1'b0;
  logic [10:0] rx = '0;
  logic [8:0] exp_q[$];
  int starts[$], ends[$];

  always @(posedge clk14) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // receiver: samples data on ps2_clk falls, closes the frame on the rise after the 11th bit
  initial forever begin
    @(negedge clk14);
    if (!rst_n) begin
      in_frame = 1'b0;
      nbits = 0;
    end else begin
      if (ps2_clk != prev_clk) edges++;
      if (!in_frame && ps2_clk && !ps2_data) begin
        in_frame = 1'b1;
        t_start = cyc;
      end
      if (prev_clk && !ps2_clk && nbits < 11) begin
        rx[nbits] = ps2_data;
        nbits++;
      end
      if (!prev_clk && ps2_clk && nbits == 11) begin
        starts.push_back(t_start);
        ends.push_back(cyc);
        chk("frame_len", cyc - t_start, FRAME);
        chk("start_bit", int'(rx[0]), 0);
        chk("stop_bit", int'(rx[10]), 1);
        chk("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("frame_par_byte", int'(rx[9:1]), int'(exp_q.pop_front()));
        nbits = 0;
        in_frame = 1'b0;
      end
    end
    prev_clk = ps2_clk;
  end

  // call just after a negedge; holds din until accepted, queueing {parity, byte} when tracked
  task automatic send(input logic [7:0] b, input logic [8:0] e, input bit track);
    bus.din = b;
    bus.din_valid = 1'b1;
    for (int k = 0; k < 4 * FRAME && !bus.din_ready; k++) @(negedge clk14);
    chk("send_accept", int'(bus.din_ready), 1);
    if (track) exp_q.push_back(e);
    @(negedge clk14);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_frames(input string name, input int target);
    for (int k = 0; k < 12 * (FRAME + GAPH * HALF + 10) && ends.size() < target; k++) @(negedge clk14);
    chk(name, ends.size(), target);
  endtask

  logic [8:0] fv [8] = '{9'h112, 9'h034, 9'h156, 9'h178, 9'h19A, 9'h0BC, 9'h1DE, 9'h1E1};
  int n0, e0;

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk14);
    chk("rst_clk", int'(ps2_clk), 1);
    chk("rst_data", int'(ps2_data), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(bus.din_ready), 1);
    rst_n = 1'b1;
    @(negedge clk14);
    // reset in the middle of a frame
    send(8'h55, 9'h0, 1'b0);
    repeat (5 * HALF + 3) @(negedge clk14);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_clk", int'(ps2_clk), 1);
    chk("abort_data", int'(ps2_data), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(bus.din_ready), 1);
    e0 = edges;
    repeat (10) @(negedge clk14);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk14);
    chk("abort_no_edges", edges, e0);
    chk("abort_no_frame", ends.size(), 0);
    // single byte 0x1C: bits 0,0,0,1,1,1,0,0,0,P=0,1
    n0 = ends.size();
    send(8'h1C, 9'h01C, 1'b1);
    wait_frames("single_done", n0 + 1);
    // parity corners
    n0 = ends.size();
    send(8'h00, 9'h100, 1'b1);
    send(8'hFF, 9'h1FF, 1'b1);
    send(8'h01, 9'h001, 1'b1);
    wait_frames("parity_done", n0 + 3);
    repeat (2 * FRAME) @(negedge clk14);
    // back-to-back: gap is GAP_HALVES half-bits plus the single IDLE pop cycle
    n0 = ends.size();
    send(8'hF0, 9'h1F0, 1'b1);
    send(8'h1C, 9'h01C, 1'b1);
    wait_frames("b2b_done", n0 + 2);
    if (ends.size() >= n0 + 2) chk_rng("b2b_gap", starts[n0 + 1] - ends[n0], GAPH * HALF, GAPH * HALF + 1);
    repeat (2 * FRAME) @(negedge clk14);
    // inhibit holds a queued byte, release starts next cycle, mid-frame inhibit is ignored
    inhibit = 1'b1;
    n0 = ends.size();
    send(8'h5A, 9'h15A, 1'b1);
    e0 = edges;
    repeat (50000) @(negedge clk14);
    chk("inh_no_edges", edges, e0);
    chk("inh_busy", int'(busy), 1);
    chk("inh_data_high", int'(ps2_data), 1);
    inhibit = 1'b0;
    @(negedge clk14);
    chk("inh_release_start", int'(ps2_data), 0);
    repeat (7 * HALF) @(negedge clk14);
    inhibit = 1'b1;
    wait_frames("inh_mid_complete", n0 + 1);
    inhibit = 1'b0;
    repeat (2 * FRAME) @(negedge clk14);
    // fill the buffer while inhibited, overflow byte is refused until re-presented
    n0 = ends.size();
    inhibit = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(fv[i][7:0], fv[i], 1'b1);
    chk("full_ready_low", int'(bus.din_ready), 0);
    bus.din = 8'h77;
    bus.din_valid = 1'b1;
    repeat (5) @(negedge clk14);
    chk("full_still_low", int'(bus.din_ready), 0);
    bus.din_valid = 1'b0;
    inhibit = 1'b0;
    wait_frames("full_drain", n0 + DEPTH);
    send(8'h77, 9'h177, 1'b1);
    wait_frames("full_extra", n0 + DEPTH + 1);
    repeat (2 * FRAME) @(negedge clk14);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_clk", int'(ps2_clk), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
